// File: rtl/trap_handler_pkg.sv
// Shared trap definitions: cause enums, CSR addresses, mstatus fields, FSM state.
package trap_handler_pkg;

  typedef enum logic [5:0] {
    EXC_INSTR_MISALIGNED = 6'd0,
    EXC_INSTR_ACCESS     = 6'd1,
    EXC_ILLEGAL_INSTR    = 6'd2,
    EXC_BREAKPOINT       = 6'd3,
    EXC_LOAD_MISALIGNED  = 6'd4,
    EXC_LOAD_ACCESS      = 6'd5,
    EXC_STORE_MISALIGNED = 6'd6,
    EXC_STORE_ACCESS     = 6'd7,
    EXC_ECALL_U          = 6'd8,
    EXC_ECALL_S          = 6'd9,
    EXC_ECALL_M          = 6'd11,
    EXC_INSTR_PAGE       = 6'd12,
    EXC_LOAD_PAGE        = 6'd13,
    EXC_STORE_PAGE       = 6'd15
  } exception;

  typedef enum logic [3:0] {
    IRQ_S_SOFT  = 4'd1,
    IRQ_M_SOFT  = 4'd3,
    IRQ_S_TIMER = 4'd5,
    IRQ_M_TIMER = 4'd7,
    IRQ_S_EXT   = 4'd9,
    IRQ_M_EXT   = 4'd11
  } interrupt;

  // Highest priority at the top index.
  localparam logic [5:0][3:0] IRQ_PRIO = {4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_FLUSH} trap_state_e;
  typedef enum logic [1:0] {EV_EXC, EV_IRQ, EV_MRET} trap_kind_e;

endpackage

// File: rtl/trap_handler_irq.sv
// Fixed-priority pick over enabled pending interrupts (code = mip bit index).
module irq_arbiter
  import trap_handler_pkg::*;
(
  input  logic [11:0] pend,
  output logic        vld,
  output logic [3:0]  code
);
  always_comb begin
    vld  = 1'b0;
    code = '0;
    // Ascending walk: the last hit is the highest priority.
    for (int i = 0; i < 6; i++) begin
      if (pend[IRQ_PRIO[i]]) begin
        vld  = 1'b1;
        code = IRQ_PRIO[i];
      end
    end
  end
endmodule

// File: rtl/trap_handler.sv
// M-mode trap responder: owns trap CSRs and issues a flush/redirect on exception, irq or mret.
// Build option TRAP_VECTORED_EN enables mtvec vectored mode for interrupts.
module trap_handler
  import trap_handler_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_exc_vld,
  input  logic [5:0]      i_exc_cause,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic            i_mret_vld,
  input  logic            i_irq_pc_vld,
  input  logic [XLEN-1:0] i_irq_pc,
  input  logic [XLEN-1:0] i_mip,
  input  logic [XLEN-1:0] i_mie,
  input  logic            i_csr_wen,
  input  logic [11:0]     i_csr_widx,
  input  logic [XLEN-1:0] i_csr_wdata,
  input  logic [11:0]     i_csr_ridx,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_busy,
  output logic            o_flush_vld,
  output logic [XLEN-1:0] o_flush_pc,
  input  logic            i_flush_ack
);
  trap_state_e     state_q, state_d;
  trap_kind_e      kind_q;
  logic [3:0]      code_q;
  logic            mie_q, mpie_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, mtvec_q;
  logic [XLEN-1:0] pend, mtvec_base;
  logic            arb_vld, vec_mode, is_idle;
  logic            take_exc, take_mret, take_irq;
  logic [3:0]      arb_code;
  logic [1:0]      mtvec_wr_lo, mtvec_rst_lo;
  logic            unused_bits;

  assign pend        = i_mip & i_mie;
  assign unused_bits = ^{pend[XLEN-1:12], i_exc_pc[0]};

  irq_arbiter u_arb (.pend(pend[11:0]), .vld(arb_vld), .code(arb_code));

`ifdef TRAP_VECTORED_EN
  // Mode field is WARL: only direct (0) and vectored (1) survive.
  assign mtvec_wr_lo  = (i_csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00;
  assign mtvec_rst_lo = (MTVEC_RST[1:0] == 2'b01) ? 2'b01 : 2'b00;
  assign vec_mode     = mtvec_q[0];
`else
  assign mtvec_wr_lo  = 2'b00;
  assign mtvec_rst_lo = 2'b00;
  assign vec_mode     = 1'b0;
`endif

  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign is_idle    = (state_q == ST_IDLE);
  assign take_exc   = is_idle & i_exc_vld;
  assign take_mret  = is_idle & ~i_exc_vld & i_mret_vld;
  assign take_irq   = is_idle & ~i_exc_vld & ~i_mret_vld & mie_q & i_irq_pc_vld & arb_vld;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (take_exc | take_mret | take_irq) state_d = ST_SAVE;
      ST_SAVE:  state_d = ST_FLUSH;
      ST_FLUSH: if (i_flush_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != ST_IDLE);
    o_flush_vld = (state_q == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mtvec_q    <= {MTVEC_RST[XLEN-1:2], mtvec_rst_lo};
      kind_q     <= EV_EXC;
      code_q     <= '0;
      o_flush_pc <= '0;
    end else begin
      if (is_idle && i_csr_wen) begin
        case (i_csr_widx)
          CSR_MSTATUS: begin
            mie_q  <= i_csr_wdata[MSTATUS_MIE];
            mpie_q <= i_csr_wdata[MSTATUS_MPIE];
          end
          CSR_MTVEC:  mtvec_q  <= {i_csr_wdata[XLEN-1:2], mtvec_wr_lo};
          CSR_MEPC:   mepc_q   <= {i_csr_wdata[XLEN-1:1], 1'b0};
          CSR_MCAUSE: mcause_q <= i_csr_wdata;
          CSR_MTVAL:  mtval_q  <= i_csr_wdata;
          default: ;
        endcase
      end
      // Trap updates come after the CSR write so they win on overlapping fields.
      if (take_exc) begin
        mepc_q   <= {i_exc_pc[XLEN-1:1], 1'b0};
        mcause_q <= {{(XLEN-6){1'b0}}, i_exc_cause};
        mtval_q  <= i_exc_tval;
        kind_q   <= EV_EXC;
      end
      if (take_irq) begin
        mepc_q   <= i_irq_pc;
        mcause_q <= {1'b1, {(XLEN-5){1'b0}}, arb_code};
        mtval_q  <= '0;
        kind_q   <= EV_IRQ;
        code_q   <= arb_code;
      end
      if (take_exc | take_irq) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end
      if (take_mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
        kind_q <= EV_MRET;
      end
      if (state_q == ST_SAVE) begin
        case (kind_q)
          EV_IRQ:  o_flush_pc <= vec_mode ? mtvec_base + {{(XLEN-6){1'b0}}, code_q, 2'b00}
                                          : mtvec_base;
          EV_MRET: o_flush_pc <= mepc_q;
          default: o_flush_pc <= mtvec_base;
        endcase
      end
    end
  end

  always_comb begin
    o_csr_rdata = '0;
    case (i_csr_ridx)
      CSR_MSTATUS: begin
        o_csr_rdata[MSTATUS_MIE]                   = mie_q;
        o_csr_rdata[MSTATUS_MPIE]                  = mpie_q;
        o_csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MTVEC:  o_csr_rdata = mtvec_q;
      CSR_MEPC:   o_csr_rdata = mepc_q;
      CSR_MCAUSE: o_csr_rdata = mcause_q;
      CSR_MTVAL:  o_csr_rdata = mtval_q;
      default:    o_csr_rdata = '0;
    endcase
  end
endmodule

// File: doc/trap_handler.md
# trap_handler

Machine-mode trap responder at the commit end of the pipeline. It consumes exception causes reported by the ROB, pending interrupts, and `mret`. It owns the trap CSRs (`mstatus` MIE/MPIE/MPP, `mtvec`, `mepc`, `mcause`, `mtval`) and issues a pipeline flush with the redirect PC through a valid/ack handshake. Commit stalls on `o_busy`.

## Interface
Parameters:
- `XLEN`, 64, data/PC width.
- `MTVEC_RST`, 0, `mtvec` reset value.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `i_exc_vld` in 1: oldest committing instruction faulted.
- `i_exc_cause` in 6: exception code (enum `exception`).
- `i_exc_pc` in XLEN: faulting PC.
- `i_exc_tval` in XLEN: trap value.
- `i_mret_vld` in 1: committing `mret`.
- `i_irq_pc_vld` in 1: commit boundary; interrupt may be taken here.
- `i_irq_pc` in XLEN: PC of next uncommitted instruction.
- `i_mip` in XLEN: pending interrupt bits; bit index equals interrupt code.
- `i_mie` in XLEN: interrupt enable bits.
- `i_csr_wen` in 1: CSR write enable.
- `i_csr_widx` in 12: write address.
- `i_csr_wdata` in XLEN: write data.
- `i_csr_ridx` in 12: read address.
- `o_csr_rdata` out XLEN: combinational read; 0 for unowned addresses.
- `o_busy` out 1: state ≠ IDLE.
- `o_flush_vld` out 1: flush request.
- `o_flush_pc` out XLEN: redirect target.
- `i_flush_ack` in 1: frontend/backend accepted flush.

## Operation
- **States:** IDLE, SAVE, FLUSH.
- **Event priority in IDLE:** exception > `mret` > interrupt. Lower-priority events are dropped in the same cycle; the ROB re-presents them.
- **Interrupt take condition:** `mstatus.MIE` & `i_irq_pc_vld` & `|(i_mip & i_mie)`.
- **Interrupt arbitration order:** mExter(11) > mSoft(3) > mTimer(7) > sExter(9) > sSoft(1) > sTimer(5).
- **Exception accept** (edge ending IDLE cycle):
  - `mepc` ← `{i_exc_pc[XLEN-1:1],0}`.
  - `mcause` ← `{0,cause}`.
  - `mtval` ← `i_exc_tval`.
  - MPIE ← MIE, MIE ← 0, MPP ← 2'b11.
  - Go to SAVE.
- **Interrupt accept:**
  - `mepc` ← `i_irq_pc`.
  - `mcause` ← `{1,0…,code}` (MSB set).
  - `mtval` ← 0.
  - Same `mstatus` update as exception.
  - Go to SAVE.
- **`mret` accept:** MIE ← MPIE, MPIE ← 1, MPP ← 2'b11. Go to SAVE.
- **SAVE:** registers `o_flush_pc`, then goes to FLUSH.
  - Exception: `mtvec & ~3`.
  - Interrupt: base + 4×code if mode=1, else base.
  - `mret`: `mepc`.
- **FLUSH:** `o_flush_vld`=1 and `o_flush_pc` stable until `i_flush_ack` is sampled high. Then IDLE.
- **CSR writes:**
  - Honoured only in IDLE; ignored otherwise.
  - A CSR write in the same cycle as an accepted event is overridden by the trap update for overlapping fields.
  - `mepc` bit0 is forced to 0.
  - `mstatus`: only MIE/MPIE are writable; MPP reads 2'b11; all other bits read 0.
  - `mtvec` mode is WARL: values 2 and 3 store 0.
- **Width rule:** vectored target is `base + {code,2'b00}`, truncated to XLEN with no overflow trap.

## Timing
- Reset values:
  - `o_flush_vld`=0, `o_flush_pc`=0, `o_busy`=0.
  - `mepc`/`mcause`/`mtval`=0.
  - MIE=MPIE=0, MPP=2'b11.
  - `mtvec`=`MTVEC_RST`.
  - State IDLE.
- Event in cycle N:
  - CSRs visible on `o_csr_rdata` in N+1.
  - `o_busy`=1 from N+1.
  - `o_flush_vld`=1 from N+2.
- `i_flush_ack` high in cycle M, with `o_flush_vld`=1 in M: `o_flush_vld`=0 and `o_busy`=0 from M+1. Minimum occupancy is 3 cycles.
- `i_flush_ack` while not in FLUSH: ignored.
- `rst` in any state: IDLE next cycle, `o_flush_vld` drops, CSRs take reset values.

## Configuration
- **`TRAP_VECTORED_EN` defined:**
  - `mtvec` mode bit0 is writable.
  - Interrupts in mode 1 vector to base + 4×code.
- **Undefined:**
  - `mtvec[1:0]` is hardwired 0; writes to those bits are ignored.
  - All traps go to base.

## Structure
- Shared core definitions header holds:
  - Trap-cause enums `exception`/`interrupt` (reused).
  - CSR address constants: MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342, MTVAL=0x343.
  - `mstatus` bit positions MIE=3, MPIE=7, MPP=12:11.
  - Trap state enum.
- One sub-module, `irq_arbiter`: combinational fixed-priority pick over `i_mip & i_mie`, giving valid + 4-bit code.

## Test plan
- **Exception:** `mtvec`=0x8000_0100, `i_exc_vld` with cause=2, pc=0x1003, tval=0xDEAD.
  - `mepc`=0x1002, `mcause`=2, `mtval`=0xDEAD.
  - `o_flush_pc`=0x8000_0100 at N+2.
  - MIE=0, MPIE=old MIE.
- **Vectored interrupt:** `TRAP_VECTORED_EN`, `mtvec`=0x8000_0001, MIE=1, `i_mip`=`i_mie`=0x880, `i_irq_pc`=0x2000.
  - mExter wins: `mcause`=0x8000…000B, `mepc`=0x2000.
  - `o_flush_pc`=0x8000_002C.
- **Interrupt masked:** MIE=0 with `i_mip`&`i_mie`≠0 → no flush, `o_busy` stays 0.
- **`mret`:** `mepc`=0x3000, MPIE=1 → `o_flush_pc`=0x3000, MIE=1, MPIE=1.
- **Simultaneous events and held flush:** exception + `mret` + interrupt in the same cycle → only the exception is taken. Holding `i_flush_ack`=0 for 5 cycles keeps `o_flush_vld`/`o_flush_pc` stable. A CSR write to `mtvec` during busy is ignored.
- **Reset mid-flush:** `rst` in FLUSH → `o_flush_vld`=0 next cycle, MPP=2'b11, `mtvec`=`MTVEC_RST`.
